// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny CPU, its word memory and the copy engine.
package tiny_cpu_pkg;

  typedef enum logic [1:0] {
    CmdNop   = 2'b00,
    CmdRead  = 2'b01,
    CmdWrite = 2'b10
  } mem_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StFinish
  } copy_state_e;

  // A toggle-handshake request is complete once both toggles agree.
  function automatic logic req_complete(input logic run, input logic done);
    return run == done;
  endfunction

endpackage

// File: rtl/mem_copy_engine_if.sv
// Toggle-handshake word memory port: the master flips mem_run, the responder answers on mem_done.
interface mem_copy_engine_if;
  import tiny_cpu_pkg::*;

  logic [15:0] mem_addr;
  mem_cmd_e    mem_cmd;
  logic        mem_run;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;
  logic        mem_done;

  modport master (
    output mem_addr, mem_cmd, mem_run, mem_wr_data,
    input  mem_rd_data, mem_done
  );

  modport slave (
    input  mem_addr, mem_cmd, mem_run, mem_wr_data,
    output mem_rd_data, mem_done
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: read src+i, write dst+i, over a single toggle-handshake port.
module mem_copy_engine
  import tiny_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        finished,
  output logic        aborted,
  output logic [15:0] words_done,
  mem_copy_engine_if.master mem
);

  copy_state_e state_q, state_d;
  mem_cmd_e    cmd_q, cmd_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [15:0] wd_q, wd_d, hold_q, hold_d, addr_q, addr_d, wdata_q, wdata_d;
  logic        run_q, run_d, busy_q, busy_d, fin_q, fin_d, abt_q, abt_d;
  logic        cmpl, last;
  logic [15:0] wd_inc;

  assign cmpl   = req_complete(run_q, mem.mem_done);
  assign wd_inc = wd_q + 16'd1;
  assign last   = (wd_inc == len_q);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    wd_d    = wd_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    run_d   = run_q;
    busy_d  = busy_q;
    abt_d   = abt_q;
    fin_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          wd_d    = 16'd0;
          busy_d  = 1'b1;
          abt_d   = 1'b0;
          state_d = (length == 16'd0) ? StFinish : StRdReq;
        end
      end
      StRdReq: begin
        addr_d  = src_q + wd_q;
        cmd_d   = CmdRead;
        run_d   = ~run_q;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (cmpl) begin
          hold_d = mem.mem_rd_data;
          if (abort) begin
            cmd_d   = CmdNop;
            abt_d   = 1'b1;
            state_d = StFinish;
          end else begin
            state_d = StWrReq;
          end
        end
      end
      StWrReq: begin
        addr_d  = dst_q + wd_q;
        cmd_d   = CmdWrite;
        wdata_d = hold_q;
        run_d   = ~run_q;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (cmpl) begin
          wd_d = wd_inc;
          if (last || abort) begin
            cmd_d   = CmdNop;
            // Abort only counts when it actually cut the copy short.
            abt_d   = abort && !last;
            state_d = StFinish;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StFinish: begin
        fin_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cmd_q   <= CmdNop;
      src_q   <= 16'd0;
      dst_q   <= 16'd0;
      len_q   <= 16'd0;
      wd_q    <= 16'd0;
      hold_q  <= 16'd0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      wd_q    <= wd_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      abt_q   <= abt_d;
    end
  end

  assign busy            = busy_q;
  assign finished        = fin_q;
  assign aborted         = abt_q;
  assign words_done      = wd_q;
  assign mem.mem_addr    = addr_q;
  assign mem.mem_cmd     = cmd_q;
  assign mem.mem_run     = run_q;
  assign mem.mem_wr_data = wdata_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a toggle-handshake word memory of 0..3 cycle delay.
module tb_mem_copy_engine;
  import tiny_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [15:0] src_addr, dst_addr, length;
  logic        busy, finished, aborted;
  logic [15:0] words_done;

  mem_copy_engine_if mem_bus ();

  mem_copy_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .finished   (finished),
    .aborted    (aborted),
    .words_done (words_done),
    .mem        (mem_bus.master)
  );

  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          viol;
  int unsigned delay;
  int unsigned wcnt;
  logic [15:0] mem_arr [65536];
  logic [15:0] rd_log [$];
  logic [15:0] wr_log [$];

  // Memory responder: logs each request when first seen, completes it 'delay' cycles later.
  initial begin
    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0000;
    mem_arr[16'h0010] = 16'h00A1;
    mem_arr[16'h0011] = 16'h00B2;
    mem_arr[16'h0012] = 16'h00C3;
    mem_arr[16'h0013] = 16'h00D4;
    mem_arr[16'hFFFE] = 16'h1111;
    mem_arr[16'hFFFF] = 16'h2222;
    mem_arr[16'h0000] = 16'h3333;
    for (int i = 0; i < 8; i++) mem_arr[16'h0200 + i] = 16'h5A00 + 16'(i);
    wcnt = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mem_bus.mem_done    = 1'b0;
        mem_bus.mem_rd_data = 16'h0000;
        wcnt = 0;
      end else begin
        #1;
        if (!reset && (mem_bus.mem_run != mem_bus.mem_done)) begin
          if (wcnt == 0) begin
            if (mem_bus.mem_cmd == CmdRead) rd_log.push_back(mem_bus.mem_addr);
            else if (mem_bus.mem_cmd == CmdWrite) wr_log.push_back(mem_bus.mem_addr);
          end
          if (wcnt >= delay) begin
            if (mem_bus.mem_cmd == CmdRead) mem_bus.mem_rd_data = mem_arr[mem_bus.mem_addr];
            else if (mem_bus.mem_cmd == CmdWrite) mem_arr[mem_bus.mem_addr] = mem_bus.mem_wr_data;
            mem_bus.mem_done = mem_bus.mem_run;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // Request outputs and mem_run must hold while a request is outstanding.
  initial begin
    logic        p_valid, p_out, p_run;
    logic [15:0] p_addr, p_wd;
    logic [1:0]  p_cmd;
    viol    = 0;
    p_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && p_valid && p_out) begin
        if (mem_bus.mem_run !== p_run || mem_bus.mem_addr !== p_addr ||
            mem_bus.mem_cmd !== p_cmd || mem_bus.mem_wr_data !== p_wd) viol++;
      end
      p_out   = (mem_bus.mem_run != mem_bus.mem_done);
      p_run   = mem_bus.mem_run;
      p_addr  = mem_bus.mem_addr;
      p_cmd   = mem_bus.mem_cmd;
      p_wd    = mem_bus.mem_wr_data;
      p_valid = !reset;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_fin(input int budget, input string tag);
    int n;
    n = 0;
    while (!finished && n < budget) begin
      tick();
      n++;
    end
    check(tag, finished, 1'b1);
  endtask

  initial begin
    int n, first_tog, rd0, wr0;
    logic [15:0] basic_exp [4];
    basic_exp = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
    n_vec = 0;
    n_err = 0;
    delay = 0;
    start = 1'b0;
    abort = 1'b0;
    src_addr = 16'h0000;
    dst_addr = 16'h0000;
    length   = 16'h0000;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_finished", finished, 1'b0);
    check("rst_aborted", aborted, 1'b0);
    check("rst_words_done", words_done, 16'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 16'd0);
    check("rst_mem_cmd", mem_bus.mem_cmd, 2'b00);
    check("rst_mem_run", mem_bus.mem_run, 1'b0);
    check("rst_mem_wr_data", mem_bus.mem_wr_data, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic 4-word copy, zero-wait memory: 16 copy cycles then the FINISH cycle.
    launch(16'h0010, 16'h0020, 16'd4);
    check("basic_busy", busy, 1'b1);
    check("basic_no_early_run", mem_bus.mem_run, 1'b0);
    n = 0;
    first_tog = 0;
    while (!finished && n < 40) begin
      tick();
      n++;
      if (first_tog == 0 && mem_bus.mem_run != 1'b0) first_tog = n;
    end
    check("basic_fin_seen", finished, 1'b1);
    check("basic_latency", n, 17);
    check("basic_first_run", first_tog, 1);
    check("basic_words_done", words_done, 16'd4);
    check("basic_aborted", aborted, 1'b0);
    check("basic_busy_drop", busy, 1'b0);
    tick();
    check("basic_fin_pulse", finished, 1'b0);
    check("basic_cmd_idle", mem_bus.mem_cmd, 2'b00);
    for (int i = 0; i < 4; i++) check("basic_data", mem_arr[16'h0020 + i], basic_exp[i]);

    // Zero length: finished the cycle after busy rises, no memory traffic.
    rd0 = rd_log.size();
    wr0 = wr_log.size();
    launch(16'h0050, 16'h0060, 16'd0);
    check("zero_busy", busy, 1'b1);
    check("zero_fin_early", finished, 1'b0);
    tick();
    check("zero_fin", finished, 1'b1);
    check("zero_busy_drop", busy, 1'b0);
    check("zero_words_done", words_done, 16'd0);
    tick();
    check("zero_run", mem_bus.mem_run, 1'b0);
    check("zero_traffic", rd_log.size() + wr_log.size(), rd0 + wr0);

    // Source wraps from 0xFFFF to 0x0000.
    delay = 1;
    rd0 = rd_log.size();
    wr0 = wr_log.size();
    launch(16'hFFFE, 16'h0100, 16'd3);
    wait_fin(100, "wrap_timeout");
    check("wrap_reads", rd_log.size(), rd0 + 3);
    if (rd_log.size() >= rd0 + 3) begin
      check("wrap_rd0", rd_log[rd0], 16'hFFFE);
      check("wrap_rd1", rd_log[rd0 + 1], 16'hFFFF);
      check("wrap_rd2", rd_log[rd0 + 2], 16'h0000);
    end
    if (wr_log.size() >= wr0 + 3) check("wrap_wr2", wr_log[wr0 + 2], 16'h0102);
    check("wrap_d0", mem_arr[16'h0100], 16'h1111);
    check("wrap_d1", mem_arr[16'h0101], 16'h2222);
    check("wrap_d2", mem_arr[16'h0102], 16'h3333);
    check("wrap_words_done", words_done, 16'd3);
    tick();

    // Abort raised while the third read is outstanding.
    delay = 2;
    rd0 = rd_log.size();
    wr0 = wr_log.size();
    launch(16'h0200, 16'h0300, 16'd8);
    n = 0;
    while (rd_log.size() < rd0 + 3 && n < 200) begin
      tick();
      n++;
    end
    check("abort_third_read", rd_log.size(), rd0 + 3);
    abort = 1'b1;
    wait_fin(100, "abort_timeout");
    check("abort_reads", rd_log.size(), rd0 + 3);
    check("abort_writes", wr_log.size(), wr0 + 2);
    check("abort_words_done", words_done, 16'd2);
    check("abort_flag", aborted, 1'b1);
    check("abort_d1", mem_arr[16'h0301], 16'h5A01);
    check("abort_d2_untouched", mem_arr[16'h0302], 16'h0000);
    abort = 1'b0;
    tick();

    // Reset while the first write is outstanding, then a fresh copy.
    delay = 3;
    wr0 = wr_log.size();
    launch(16'h0010, 16'h0400, 16'd4);
    n = 0;
    while (wr_log.size() < wr0 + 1 && n < 100) begin
      tick();
      n++;
    end
    check("midrst_outstanding", mem_bus.mem_run ^ mem_bus.mem_done, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_finished", finished, 1'b0);
    check("midrst_words_done", words_done, 16'd0);
    check("midrst_run", mem_bus.mem_run, 1'b0);
    check("midrst_cmd", mem_bus.mem_cmd, 2'b00);
    check("midrst_addr", mem_bus.mem_addr, 16'd0);
    check("midrst_wr_data", mem_bus.mem_wr_data, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    delay = 0;
    launch(16'h0010, 16'h0500, 16'd4);
    repeat (3) tick();
    // A start while busy must be ignored.
    launch(16'h0200, 16'h0600, 16'd2);
    wait_fin(100, "fresh_timeout");
    check("fresh_words_done", words_done, 16'd4);
    check("fresh_aborted", aborted, 1'b0);
    for (int i = 0; i < 4; i++) check("fresh_data", mem_arr[16'h0500 + i], basic_exp[i]);
    check("fresh_ignored_start", mem_arr[16'h0600], 16'h0000);
    tick();
    check("fresh_after_fin", busy, 1'b0);

    check("protocol", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-004 abort  input  1  level; stops the copy at the next access boundary.
REQ-005 src_addr  input  16  first source word address; latched on accepted start.
REQ-006 dst_addr  input  16  first destination word address; latched on accepted start.
REQ-007 length  input  16  word count; latched on accepted start; 0 is legal.
REQ-008 busy  output  1  high from accepted start until FINISH is left.
REQ-009 finished  output  1  one-cycle pulse when the copy ends, normally or by abort.
REQ-010 aborted  output  1  valid with finished; high if the copy ended by abort.
REQ-011 words_done  output  16  count of words fully written in the current or last copy.
REQ-012 mem_addr  output  16  memory word address.
REQ-013 mem_cmd  output  2  nop/read/write command code.
REQ-014 mem_run  output  1  request toggle.
REQ-015 mem_wr_data  output  16  write data.
REQ-016 mem_rd_data  input  16  read data from the responder.
REQ-017 mem_done  input  1  completion toggle from the responder.

Function
REQ-018 Handshake: the block starts a request by driving mem_addr, mem_cmd and mem_wr_data and inverting mem_run, all on the same edge.
REQ-019 A request is outstanding while mem_run != mem_done and completes on the first edge at which they are equal.
REQ-020 mem_addr, mem_cmd and mem_wr_data shall stay stable while a request is outstanding.
REQ-021 The block shall keep at most one request outstanding and shall never toggle mem_run while one is outstanding.
REQ-022 Read data: mem_rd_data is captured on the edge at which read completion is detected.
REQ-023 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
REQ-024 IDLE: on start, latch inputs, clear words_done, set busy, then go to RD_REQ; if length==0, go to FINISH instead.
REQ-025 RD_REQ: issue a read of src+words_done, then go to RD_WAIT.
REQ-026 RD_WAIT: on completion, capture data into a holding register, then go to WR_REQ.
REQ-027 WR_REQ: issue a write of the held data to dst+words_done, then go to WR_WAIT.
REQ-028 WR_WAIT: on completion, increment words_done.
REQ-029 WR_WAIT exit: go to FINISH if the new words_done==length or abort is high; otherwise go to RD_REQ.
REQ-030 Abort in RD_WAIT: on read completion, go to FINISH without writing.
REQ-031 Abort in RD_REQ or WR_REQ: the request is still issued, and the abort is acted on at its completion.
REQ-032 Abort in IDLE or FINISH is ignored.
REQ-033 FINISH: pulse finished for exactly one cycle with aborted valid, drop busy, then return to IDLE.
REQ-034 mem_cmd shall be nop in IDLE and FINISH.
REQ-035 Addresses: src+i and dst+i are 16-bit and wrap modulo 2^16.
REQ-036 Copy order is strictly ascending; overlapping regions get no special handling.
REQ-037 Latency: the first mem_run toggle occurs exactly one cycle after the edge that accepts start.
REQ-038 Latency: with zero-wait completion, each word costs 4 cycles.
REQ-039 start while busy is ignored; latched parameters do not change mid-copy.

Reset
REQ-040 On reset the FSM goes to IDLE immediately, regardless of outstanding requests.
REQ-041 Reset values: mem_run=0, mem_cmd=nop, mem_addr=0, mem_wr_data=0, busy=0, finished=0, aborted=0, words_done=0.
REQ-042 The responder shares the same reset, so mem_done=0 after reset; no request is outstanding out of reset.

Structure
REQ-043 The mem_cmd codes (nop=2'b00, read=2'b01, write=2'b10) and the FSM state enum shall live in a shared package tiny_cpu_pkg, used by the CPU, the memory and this block.
REQ-044 This is a single module with no sub-module; the holding register and words_done counter are internal.

Verification
REQ-045 The bench pairs the block with the toggle-handshake word memory model, with a programmable 0..3-cycle completion delay.
REQ-046 Basic copy: mem[0x10..0x13]=A1,B2,C3,D4; src=0x10, dst=0x20, len=4 -> mem[0x20..0x23] match; finished pulses once; aborted=0; words_done=4; 16 cycles at delay 0.
REQ-047 Zero length: len=0 -> finished one cycle after busy rises; mem_run never toggles.
REQ-048 Wrap: src=0xFFFE, dst=0x0100, len=3 -> reads 0xFFFE, 0xFFFF, 0x0000 in order; data lands at 0x0100..0x0102.
REQ-049 Abort: len=8 with delay 2; abort raised during the 3rd read wait -> reads=3, writes=2, words_done=2, aborted=1.
REQ-050 Reset mid-copy: reset asserted during WR_WAIT -> all outputs at reset values in the same cycle; a fresh start then copies correctly.
REQ-051 Protocol checker: every scenario asserts stable request outputs while outstanding and no mem_run toggle while outstanding.
